uart_tx_frame: RTL and testbench
================================

UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data bits per frame; the legal range is 5..9.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic runs on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data_in, input, DATA_W bits: the frame payload.
REQ-006 SHALL have port tx_valid, input, 1 bit: a payload is offered.
REQ-007 SHALL have port tx_ready, output, 1 bit: the block can accept a payload.
REQ-008 SHALL have port baud_set, input, 3 bits: baud select.
REQ-009 SHALL have port parity_mode, input, 2 bits: 00 = none, 01 = odd, 10 = even, 11 = none.
REQ-010 SHALL have port stop2, input, 1 bit: 0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port uart_tx, output, 1 bit: the serial line, idle high.
REQ-012 SHALL have port tx_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-013 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-014 SHALL map baud_set 0..7 to 4800, 9600, 14400, 19200, 38400, 57600, 115200 and 230400 baud.
REQ-015 SHALL set the bit period to CLK_FREQ/baud clk cycles, using integer division; at 50 MHz, 115200 baud gives 434 cycles.
REQ-016 SHALL accept a payload on a rising edge where tx_valid=1 and tx_ready=1.
REQ-017 SHALL, on acceptance, latch data_in, baud_set, parity_mode and stop2; input changes during the frame SHALL have no effect.
REQ-018 SHALL drive tx_ready=1 only in IDLE, and busy = !tx_ready.
REQ-019 SHALL use states IDLE, START, DATA, PARITY and STOP.
REQ-020 SHALL make these transitions:
- IDLE to START on acceptance.
- START to DATA after one bit period.
- DATA to PARITY after DATA_W bit periods when parity is enabled, else DATA to STOP.
- PARITY to STOP after one bit period.
- STOP to IDLE after 1 or 2 bit periods.
REQ-021 SHALL drive uart_tx low starting the cycle after acceptance; that is the first START cycle.
REQ-022 SHALL send data bits LSB first.
REQ-023 SHALL make the odd-mode parity bit so that the total count of ones across data and parity is odd, and even for even mode.
REQ-024 SHALL drive uart_tx=1 during STOP and IDLE.
REQ-025 SHALL register uart_tx so it is glitch-free.
REQ-026 SHALL assert tx_done for exactly one cycle, on the last clk cycle of the final stop bit; the next cycle is IDLE with tx_ready=1.
REQ-027 SHALL give a frame length of (1 + DATA_W + P + S) × period cycles from the first START cycle to the tx_done cycle inclusive, with P = 1 if parity is enabled, else 0, and S = 1 + stop2.
REQ-028 SHALL, when tx_valid is held high, accept the next payload in the first IDLE cycle; the back-to-back gap is exactly one idle-high cycle.
REQ-029 SHALL restart the bit-period counter at every bit boundary, so no error accumulates across a frame.

Reset
REQ-030 SHALL, while rst=1, immediately and asynchronously force:
- state = IDLE, uart_tx = 1, tx_ready = 1, tx_done = 0, busy = 0;
- all counters cleared.
REQ-031 SHALL abandon any frame in progress when rst asserts mid-frame; uart_tx SHALL return high without completing the frame and without pulsing tx_done.
REQ-032 SHALL accept a new payload no earlier than the first rising edge after rst deasserts.

Verification
REQ-033 SHALL cover this case: CLK_FREQ = 50e6, baud_set = 6, parity_mode = 00, stop2 = 0, data 8'hAA -> line low for 434 cycles, then bits 0,1,0,1,0,1,0,1 at 434 cycles each, then high, with tx_done on cycle 4340.
REQ-034 SHALL cover this case: parity_mode = 01, data 8'h07 -> parity bit 0; parity_mode = 10, data 8'h07 -> parity bit 1; frame 11 bits = 4774 cycles.
REQ-035 SHALL cover this case: stop2 = 1, parity_mode = 10, data 8'h00 -> parity bit 0, two stop bits, tx_done at cycle 12 × 434 = 5208.
REQ-036 SHALL cover this case: tx_valid held high with data 8'h55 then 8'hA3 -> two frames, exactly one idle cycle between the tx_done cycle and the next start bit, and tx_ready high for one cycle.
REQ-037 SHALL cover this case: baud_set and data_in changed mid-frame -> the current frame is unchanged, and the next frame uses the new values.
REQ-038 SHALL cover this case: rst pulsed at the 3rd data bit -> uart_tx = 1 in the same cycle, no tx_done, and the next accepted frame is correct.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// Baud, parity mode and stop count are latched per frame; all outputs come straight from registers.
module uart_tx_frame #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [2:0]        baud_set,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   output logic              uart_tx,
   output logic              tx_done,
   output logic              busy
);

   localparam int CNT_W = $clog2(CLK_FREQ / 4800 + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic [CNT_W-1:0] baud_period(input logic [2:0] sel);
      case (sel)
         3'd0:    baud_period = CNT_W'(CLK_FREQ / 4800);
         3'd1:    baud_period = CNT_W'(CLK_FREQ / 9600);
         3'd2:    baud_period = CNT_W'(CLK_FREQ / 14400);
         3'd3:    baud_period = CNT_W'(CLK_FREQ / 19200);
         3'd4:    baud_period = CNT_W'(CLK_FREQ / 38400);
         3'd5:    baud_period = CNT_W'(CLK_FREQ / 57600);
         3'd6:    baud_period = CNT_W'(CLK_FREQ / 115200);
         default: baud_period = CNT_W'(CLK_FREQ / 230400);
      endcase
   endfunction

   // Odd mode inverts the data XOR so data plus parity carries an odd count of ones.
   function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic [1:0] mode);
      parity_bit = (^d) ^ (mode == 2'b01);
   endfunction

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    period_q;
   logic [CNT_W-1:0]    period_d;
   logic [3:0]          bit_q;
   logic [DATA_W-1:0]   shreg_q;
   logic                par_q;
   logic [1:0]          par_mode_q;
   logic                stop2_q;
   logic                uart_tx_q;
   logic                tx_done_q;
   logic                tx_ready_q;
   logic                cnt_end_s;
   logic                done_pre_s;
   logic                last_stop_s;
   logic                par_en_s;

   // Per-bit timing and frame-shape decodes.
   always_comb begin
      period_d    = baud_period(baud_set);
      cnt_end_s   = (cnt_q == period_q - CNT_W'(1));
      done_pre_s  = (cnt_q == period_q - CNT_W'(2));
      last_stop_s = (bit_q == {3'b000, stop2_q});
      par_en_s    = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
   end

   // Frame sequencer; tx_done is raised one cycle early so it lands on the final stop cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         period_q   <= '0;
         bit_q      <= 4'd0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         par_mode_q <= 2'b00;
         stop2_q    <= 1'b0;
         uart_tx_q  <= 1'b1;
         tx_done_q  <= 1'b0;
         tx_ready_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               uart_tx_q <= 1'b1;
               tx_done_q <= 1'b0;
               if (tx_valid && tx_ready_q) begin
                  shreg_q    <= data_in;
                  par_q      <= parity_bit(data_in, parity_mode);
                  par_mode_q <= parity_mode;
                  stop2_q    <= stop2;
                  period_q   <= period_d;
                  cnt_q      <= '0;
                  bit_q      <= 4'd0;
                  uart_tx_q  <= 1'b0;
                  tx_ready_q <= 1'b0;
                  state_q    <= START;
               end
            end
            START: begin
               tx_done_q <= 1'b0;
               if (cnt_end_s) begin
                  cnt_q     <= '0;
                  bit_q     <= 4'd0;
                  uart_tx_q <= shreg_q[0];
                  shreg_q   <= shreg_q >> 1;
                  state_q   <= DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               tx_done_q <= 1'b0;
               if (cnt_end_s) begin
                  cnt_q <= '0;
                  if (bit_q == 4'(DATA_W - 1)) begin
                     bit_q <= 4'd0;
                     if (par_en_s) begin
                        uart_tx_q <= par_q;
                        state_q   <= PARITY;
                     end else begin
                        uart_tx_q <= 1'b1;
                        state_q   <= STOP;
                     end
                  end else begin
                     bit_q     <= bit_q + 4'd1;
                     uart_tx_q <= shreg_q[0];
                     shreg_q   <= shreg_q >> 1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            PARITY: begin
               tx_done_q <= 1'b0;
               if (cnt_end_s) begin
                  cnt_q     <= '0;
                  bit_q     <= 4'd0;
                  uart_tx_q <= 1'b1;
                  state_q   <= STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               uart_tx_q <= 1'b1;
               tx_done_q <= last_stop_s && done_pre_s;
               if (cnt_end_s) begin
                  cnt_q <= '0;
                  if (last_stop_s) begin
                     bit_q      <= 4'd0;
                     tx_ready_q <= 1'b1;
                     state_q    <= IDLE;
                  end else begin
                     bit_q <= bit_q + 4'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_q      <= '0;
               bit_q      <= 4'd0;
               uart_tx_q  <= 1'b1;
               tx_done_q  <= 1'b0;
               tx_ready_q <= 1'b1;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign uart_tx  = uart_tx_q;
   assign tx_done  = tx_done_q;
   assign tx_ready = tx_ready_q;
   assign busy     = ~tx_ready_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at 50 MHz: line levels sampled mid-bit, frame length, handshake and reset abort.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       tx_valid;
   logic       tx_ready;
   logic [2:0] baud_set;
   logic [1:0] parity_mode;
   logic       stop2;
   logic       uart_tx;
   logic       tx_done;
   logic       busy;

   int checks = 0;
   int errors = 0;

   uart_tx_frame #(.CLK_FREQ(50_000_000), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .baud_set(baud_set), .parity_mode(parity_mode), .stop2(stop2),
      .uart_tx(uart_tx), .tx_done(tx_done), .busy(busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) chk({tag, " ready_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic send(input string tag, input logic [7:0] d, input logic [2:0] b,
                       input logic [1:0] pm, input logic s2);
      wait_ready(tag);
      data_in     = d;
      baud_set    = b;
      parity_mode = pm;
      stop2       = s2;
      tx_valid    = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   // Runs from the cycle after acceptance up to the tx_done cycle; exp[k] is the line level of bit k.
   task automatic check_frame(input string tag, input logic [15:0] exp, input int nbits, input int per);
      int done_at = 0;
      int last = nbits * per;
      for (int c = 1; c <= last + 4 && done_at == 0; c++) begin
         @(negedge clk);
         if (c == 1) chk({tag, " start_first"}, uart_tx, 32'd0);
         if ((c % per) == per / 2 && (c / per) < nbits)
            chk($sformatf("%s bit%0d", tag, c / per), uart_tx, exp[c / per]);
         if (tx_done) done_at = c;
      end
      chk({tag, " done_cycle"}, done_at, last);
      chk({tag, " line_at_done"}, uart_tx, 32'd1);
   endtask

   initial begin
      int pulses;
      rst = 1'b1; data_in = 8'h00; tx_valid = 1'b0;
      baud_set = 3'd6; parity_mode = 2'b00; stop2 = 1'b0;
      #2;
      chk("rst uart_tx", uart_tx, 32'd1);
      chk("rst tx_ready", tx_ready, 32'd1);
      chk("rst busy", busy, 32'd0);
      chk("rst tx_done", tx_done, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      send("aa", 8'hAA, 3'd6, 2'b00, 1'b0);
      chk("aa busy", busy, 32'd1);
      check_frame("aa", 16'b1_10101010_0, 10, 434);

      send("odd07", 8'h07, 3'd6, 2'b01, 1'b0);
      check_frame("odd07", 16'b1_0_00000111_0, 11, 434);

      send("even07", 8'h07, 3'd6, 2'b10, 1'b0);
      check_frame("even07", 16'b1_1_00000111_0, 11, 434);

      send("stop2", 8'h00, 3'd6, 2'b10, 1'b1);
      check_frame("stop2", 16'b11_0_00000000_0, 12, 434);

      // Back-to-back with tx_valid held high.
      wait_ready("b2b");
      data_in = 8'h55; baud_set = 3'd6; parity_mode = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
      @(posedge clk);
      #1 data_in = 8'hA3;
      check_frame("b2b_1", 16'b1_01010101_0, 10, 434);
      @(negedge clk);
      chk("b2b idle ready", tx_ready, 32'd1);
      chk("b2b idle line", uart_tx, 32'd1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      check_frame("b2b_2", 16'b1_10100011_0, 10, 434);

      // Inputs changed mid-frame must not disturb the frame in flight.
      send("chg", 8'hAA, 3'd6, 2'b00, 1'b0);
      fork
         check_frame("chg_old", 16'b1_10101010_0, 10, 434);
         begin
            repeat (1000) @(posedge clk);
            #1 data_in = 8'h3C; baud_set = 3'd7; parity_mode = 2'b01; stop2 = 1'b1;
         end
      join
      send("chg_new", 8'h3C, 3'd7, 2'b00, 1'b0);
      check_frame("chg_new", 16'b1_00111100_0, 10, 217);

      // Reset during the third data bit abandons the frame.
      send("rstmid", 8'hF0, 3'd6, 2'b00, 1'b0);
      repeat (1500) @(negedge clk);
      chk("rstmid line_before", uart_tx, 32'd0);
      rst = 1'b1;
      #1;
      chk("rstmid line_async", uart_tx, 32'd1);
      chk("rstmid ready_async", tx_ready, 32'd1);
      chk("rstmid busy_async", busy, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (tx_done) pulses++;
      end
      chk("rstmid no_done", pulses, 32'd0);
      chk("rstmid line_idle", uart_tx, 32'd1);
      send("after_rst", 8'h5A, 3'd6, 2'b00, 1'b0);
      check_frame("after_rst", 16'b1_01011010_0, 10, 434);
      @(negedge clk);
      chk("after_rst ready", tx_ready, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
